// File: rtl/register_file_rename.sv
// Architectural register file with per-register rename tags, commit write-back and operand lookup.
// Optional commit/flush trace is enabled by defining RF_DUMP_EN.
module register_file_rename #(
    parameter int ROB_IDX_WD = 4,
    parameter int NREG       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_wrong_flag,
    input  logic        ID_rename_flag,
    input  logic [4:0]  ID_rename_rd,
    input  logic [31:0] ID_rename_rob_id,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    output logic        RS1_ready,
    output logic [31:0] RS1_val,
    output logic [31:0] RS1_tag,
    output logic        RS2_ready,
    output logic [31:0] RS2_val,
    output logic [31:0] RS2_tag,
    input  logic        ROB_cmt_rf_flag,
    input  logic [4:0]  ROB_cmt_rf_rd,
    input  logic [31:0] ROB_cmt_rf_rob_id,
    input  logic [31:0] ROB_cmt_rf_val,
    output logic [31:0] RF_id1,
    output logic [31:0] RF_id2,
    input  logic        RF_id1_ready,
    input  logic        RF_id2_ready,
    input  logic [31:0] RF_id1_val,
    input  logic [31:0] RF_id2_val
);

    // ROB ids are kept at full width; the index width only needs to be sane.
    if (ROB_IDX_WD < 1 || ROB_IDX_WD > 32) begin : gBadRobIdxWd
        $error("register_file_rename: ROB_IDX_WD out of range");
    end

    logic [31:0]     regs_q [NREG];
    logic [31:0]     regs_d [NREG];
    logic [31:0]     tag_q  [NREG];
    logic [31:0]     tag_d  [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic cmtValid;
    logic renameValid;

    assign cmtValid    = ROB_cmt_rf_flag && (ROB_cmt_rf_rd != 5'd0);
    assign renameValid = ID_rename_flag && (ID_rename_rd != 5'd0) && !jump_wrong_flag;

    // Rename is applied after commit so a same-rd rename keeps the register busy on its new tag.
    always_comb begin
        regs_d = regs_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (rdy) begin
            if (cmtValid) begin
                regs_d[ROB_cmt_rf_rd] = ROB_cmt_rf_val;
                if (busy_q[ROB_cmt_rf_rd] && (tag_q[ROB_cmt_rf_rd] == ROB_cmt_rf_rob_id)) begin
                    busy_d[ROB_cmt_rf_rd] = 1'b0;
                end
            end
            if (jump_wrong_flag) begin
                busy_d = '0;
            end else if (renameValid) begin
                busy_d[ID_rename_rd] = 1'b1;
                tag_d[ID_rename_rd]  = ID_rename_rob_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    assign RF_id1  = tag_q[ID_rs1];
    assign RF_id2  = tag_q[ID_rs2];
    assign RS1_tag = tag_q[ID_rs1];
    assign RS2_tag = tag_q[ID_rs2];

    // The commit bypass covers the cycle in which the ROB has already dropped the entry's ready bit.
    always_comb begin
        RS1_ready = 1'b0;
        RS1_val   = '0;
        if (ID_rs1 == 5'd0) begin
            RS1_ready = 1'b1;
        end else if (!busy_q[ID_rs1]) begin
            RS1_ready = 1'b1;
            RS1_val   = regs_q[ID_rs1];
        end else if (ROB_cmt_rf_flag && (ROB_cmt_rf_rd == ID_rs1)
                     && (ROB_cmt_rf_rob_id == tag_q[ID_rs1])) begin
            RS1_ready = 1'b1;
            RS1_val   = ROB_cmt_rf_val;
        end else if (RF_id1_ready) begin
            RS1_ready = 1'b1;
            RS1_val   = RF_id1_val;
        end
    end

    always_comb begin
        RS2_ready = 1'b0;
        RS2_val   = '0;
        if (ID_rs2 == 5'd0) begin
            RS2_ready = 1'b1;
        end else if (!busy_q[ID_rs2]) begin
            RS2_ready = 1'b1;
            RS2_val   = regs_q[ID_rs2];
        end else if (ROB_cmt_rf_flag && (ROB_cmt_rf_rd == ID_rs2)
                     && (ROB_cmt_rf_rob_id == tag_q[ID_rs2])) begin
            RS2_ready = 1'b1;
            RS2_val   = ROB_cmt_rf_val;
        end else if (RF_id2_ready) begin
            RS2_ready = 1'b1;
            RS2_val   = RF_id2_val;
        end
    end

`ifdef RF_DUMP_EN
    integer cmtCount;

    initial begin
        cmtCount = 0;
    end

    always @(posedge clk) begin
        if (!rst && rdy) begin
            if (cmtValid) begin
                cmtCount = cmtCount + 1;
                $display("%0d %0d %h", cmtCount, ROB_cmt_rf_rd, ROB_cmt_rf_val);
            end
            if (jump_wrong_flag) begin
                $display("FLUSH");
            end
        end
    end
`endif

endmodule

// File: tb/tb_register_file_rename.sv
// Directed self-checking bench for register_file_rename: rename, commit, bypass and flush scenarios.
module tb_register_file_rename;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        jump_wrong_flag;
    logic        ID_rename_flag;
    logic [4:0]  ID_rename_rd;
    logic [31:0] ID_rename_rob_id;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        RS1_ready;
    logic [31:0] RS1_val;
    logic [31:0] RS1_tag;
    logic        RS2_ready;
    logic [31:0] RS2_val;
    logic [31:0] RS2_tag;
    logic        ROB_cmt_rf_flag;
    logic [4:0]  ROB_cmt_rf_rd;
    logic [31:0] ROB_cmt_rf_rob_id;
    logic [31:0] ROB_cmt_rf_val;
    logic [31:0] RF_id1;
    logic [31:0] RF_id2;
    logic        RF_id1_ready;
    logic        RF_id2_ready;
    logic [31:0] RF_id1_val;
    logic [31:0] RF_id2_val;

    int assertCount = 0;
    int failCount   = 0;

    register_file_rename dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .jump_wrong_flag   (jump_wrong_flag),
        .ID_rename_flag    (ID_rename_flag),
        .ID_rename_rd      (ID_rename_rd),
        .ID_rename_rob_id  (ID_rename_rob_id),
        .ID_rs1            (ID_rs1),
        .ID_rs2            (ID_rs2),
        .RS1_ready         (RS1_ready),
        .RS1_val           (RS1_val),
        .RS1_tag           (RS1_tag),
        .RS2_ready         (RS2_ready),
        .RS2_val           (RS2_val),
        .RS2_tag           (RS2_tag),
        .ROB_cmt_rf_flag   (ROB_cmt_rf_flag),
        .ROB_cmt_rf_rd     (ROB_cmt_rf_rd),
        .ROB_cmt_rf_rob_id (ROB_cmt_rf_rob_id),
        .ROB_cmt_rf_val    (ROB_cmt_rf_val),
        .RF_id1            (RF_id1),
        .RF_id2            (RF_id2),
        .RF_id1_ready      (RF_id1_ready),
        .RF_id2_ready      (RF_id2_ready),
        .RF_id1_val        (RF_id1_val),
        .RF_id2_val        (RF_id2_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic driveIdle();
        jump_wrong_flag   = 1'b0;
        ID_rename_flag    = 1'b0;
        ID_rename_rd      = '0;
        ID_rename_rob_id  = '0;
        ROB_cmt_rf_flag   = 1'b0;
        ROB_cmt_rf_rd     = '0;
        ROB_cmt_rf_rob_id = '0;
        ROB_cmt_rf_val    = '0;
        RF_id1_ready      = 1'b0;
        RF_id2_ready      = 1'b0;
        RF_id1_val        = '0;
        RF_id2_val        = '0;
    endtask

    // Clock one edge, then return to the falling edge so inputs change away from posedge.
    task automatic tick();
        @(posedge clk);
        #1;
        driveIdle();
        @(negedge clk);
    endtask

    task automatic rename(input logic [4:0] rd, input logic [31:0] id);
        ID_rename_flag   = 1'b1;
        ID_rename_rd     = rd;
        ID_rename_rob_id = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] id, input logic [31:0] val);
        ROB_cmt_rf_flag   = 1'b1;
        ROB_cmt_rf_rd     = rd;
        ROB_cmt_rf_rob_id = id;
        ROB_cmt_rf_val    = val;
    endtask

    task automatic test_reset();
        driveIdle();
        rdy = 1'b1;
        rst = 1'b1;
        ID_rs1 = 5'd5;
        ID_rs2 = 5'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        assertCount++;
        if ({RS1_ready, RS1_val, RS1_tag, RF_id1} !== {1'b1, 32'h0, 32'h0, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL reset_rs1: got ready=%b val=%h tag=%h id=%h, want 1/0/0/0",
                     RS1_ready, RS1_val, RS1_tag, RF_id1);
        end
        assertCount++;
        if ({RS2_ready, RS2_val, RS2_tag, RF_id2} !== {1'b1, 32'h0, 32'h0, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL reset_rs2: got ready=%b val=%h tag=%h id=%h, want 1/0/0/0",
                     RS2_ready, RS2_val, RS2_tag, RF_id2);
        end
    endtask

    task automatic test_rename_pending();
        rename(5'd3, 32'd7);
        tick();
        ID_rs1 = 5'd3;
        #1;
        assertCount++;
        if ({RS1_ready, RS1_tag, RF_id1} !== {1'b0, 32'd7, 32'd7}) begin
            failCount++;
            $display("[TB] FAIL pending_rs1: got ready=%b tag=%0d id=%0d, want 0/7/7",
                     RS1_ready, RS1_tag, RF_id1);
        end
        RF_id1_ready = 1'b1;
        RF_id1_val   = 32'h55;
        #1;
        assertCount++;
        if ({RS1_ready, RS1_val} !== {1'b1, 32'h55}) begin
            failCount++;
            $display("[TB] FAIL rob_forward_rs1: got ready=%b val=%h, want 1/00000055",
                     RS1_ready, RS1_val);
        end
        @(negedge clk);
        driveIdle();
    endtask

    task automatic test_rename_chain();
        rename(5'd3, 32'd7);
        tick();
        rename(5'd3, 32'd9);
        tick();
        commit(5'd3, 32'd7, 32'h11);
        tick();
        ID_rs1 = 5'd3;
        #1;
        assertCount++;
        if ({RS1_ready, RS1_tag} !== {1'b0, 32'd9}) begin
            failCount++;
            $display("[TB] FAIL stale_commit_keeps_busy: got ready=%b tag=%0d, want 0/9",
                     RS1_ready, RS1_tag);
        end
        commit(5'd3, 32'd9, 32'h22);
        tick();
        ID_rs1 = 5'd3;
        #1;
        assertCount++;
        if ({RS1_ready, RS1_val} !== {1'b1, 32'h22}) begin
            failCount++;
            $display("[TB] FAIL owner_commit_clears: got ready=%b val=%h, want 1/00000022",
                     RS1_ready, RS1_val);
        end
    endtask

    task automatic test_commit_bypass();
        rename(5'd4, 32'd12);
        tick();
        ID_rs2 = 5'd4;
        commit(5'd4, 32'd11, 32'h1234);
        #1;
        assertCount++;
        if (RS2_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bypass_wrong_id: got ready=%b, want 0", RS2_ready);
        end
        commit(5'd4, 32'd12, 32'hABCD);
        #1;
        assertCount++;
        if ({RS2_ready, RS2_val, RF_id2} !== {1'b1, 32'hABCD, 32'd12}) begin
            failCount++;
            $display("[TB] FAIL commit_bypass_rs2: got ready=%b val=%h id=%0d, want 1/0000abcd/12",
                     RS2_ready, RS2_val, RF_id2);
        end
        tick();
        ID_rs2 = 5'd4;
        #1;
        assertCount++;
        if ({RS2_ready, RS2_val} !== {1'b1, 32'hABCD}) begin
            failCount++;
            $display("[TB] FAIL after_bypass_rs2: got ready=%b val=%h, want 1/0000abcd",
                     RS2_ready, RS2_val);
        end
    endtask

    task automatic test_rename_commit_same();
        rename(5'd8, 32'd20);
        commit(5'd8, 32'd15, 32'h1);
        tick();
        ID_rs1 = 5'd8;
        #1;
        assertCount++;
        if ({RS1_ready, RS1_tag} !== {1'b0, 32'd20}) begin
            failCount++;
            $display("[TB] FAIL same_cycle_rename_busy: got ready=%b tag=%0d, want 0/20",
                     RS1_ready, RS1_tag);
        end
        jump_wrong_flag = 1'b1;
        tick();
        ID_rs1 = 5'd8;
        #1;
        assertCount++;
        if ({RS1_ready, RS1_val} !== {1'b1, 32'h1}) begin
            failCount++;
            $display("[TB] FAIL same_cycle_value_written: got ready=%b val=%h, want 1/00000001",
                     RS1_ready, RS1_val);
        end
    endtask

    task automatic test_flush();
        rename(5'd1, 32'd5);
        tick();
        rename(5'd2, 32'd6);
        tick();
        jump_wrong_flag = 1'b1;
        commit(5'd1, 32'd5, 32'h1004);
        rename(5'd9, 32'd30);
        tick();
        ID_rs1 = 5'd1;
        ID_rs2 = 5'd2;
        #1;
        assertCount++;
        if ({RS1_ready, RS1_val} !== {1'b1, 32'h1004}) begin
            failCount++;
            $display("[TB] FAIL flush_link_x1: got ready=%b val=%h, want 1/00001004",
                     RS1_ready, RS1_val);
        end
        assertCount++;
        if ({RS2_ready, RS2_val} !== {1'b1, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL flush_x2: got ready=%b val=%h, want 1/00000000",
                     RS2_ready, RS2_val);
        end
        ID_rs1 = 5'd9;
        #1;
        assertCount++;
        if ({RS1_ready, RS1_val} !== {1'b1, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL flush_drops_rename_x9: got ready=%b val=%h, want 1/00000000",
                     RS1_ready, RS1_val);
        end
    endtask

    task automatic test_hold_and_x0();
        rdy = 1'b0;
        rename(5'd10, 32'd40);
        tick();
        rdy = 1'b1;
        ID_rs1 = 5'd10;
        #1;
        assertCount++;
        if ({RS1_ready, RS1_val} !== {1'b1, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL rdy_low_hold: got ready=%b val=%h, want 1/00000000",
                     RS1_ready, RS1_val);
        end
        rename(5'd0, 32'd50);
        commit(5'd0, 32'd50, 32'hDEAD);
        tick();
        ID_rs1 = 5'd0;
        ID_rs2 = 5'd0;
        #1;
        assertCount++;
        if ({RS1_ready, RS1_val, RF_id1} !== {1'b1, 32'h0, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL x0_ignored: got ready=%b val=%h id=%h, want 1/0/0",
                     RS1_ready, RS1_val, RF_id1);
        end
    endtask

    initial begin
        rdy    = 1'b1;
        rst    = 1'b1;
        ID_rs1 = '0;
        ID_rs2 = '0;
        driveIdle();
        test_reset();
        test_rename_pending();
        test_rename_chain();
        test_commit_bypass();
        test_rename_commit_same();
        test_flush();
        test_hold_and_x0();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
